// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encryptor: S-box and Rcon tables,
// GF(2^8) helpers, FSM state type and the on-the-fly key-schedule step.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [4:0] idx);
    case (idx)
      5'd1:    return 8'h01;
      5'd2:    return 8'h02;
      5'd3:    return 8'h04;
      5'd4:    return 8'h08;
      5'd5:    return 8'h10;
      5'd6:    return 8'h20;
      5'd7:    return 8'h40;
      5'd8:    return 8'h80;
      5'd9:    return 8'h1b;
      5'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Window in: keys up to round rnd-1 (AES-128 in the low half). Window out:
  // round rnd's key in the low 128 bits. AES-256 round 1 needs no step.
  function automatic logic [255:0] ks_next(input logic [255:0] win,
                                           input logic [4:0]   rnd,
                                           input logic         aes256);
    logic [4:0]  step;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    step = rnd - 5'd1;
    if (!aes256)
      t = sub_word(rot_word(win[31:0])) ^ {rcon(rnd), 24'h0};
    else if (step[0])
      t = sub_word(rot_word(win[31:0])) ^ {rcon((step + 5'd1) >> 1), 24'h0};
    else
      t = sub_word(win[31:0]);
    n0 = (aes256 ? win[255:224] : win[127:96]) ^ t;
    n1 = (aes256 ? win[223:192] : win[95:64])  ^ n0;
    n2 = (aes256 ? win[191:160] : win[63:32])  ^ n1;
    n3 = (aes256 ? win[159:128] : win[31:0])   ^ n2;
    if (!aes256)
      return {128'h0, n0, n1, n2, n3};
    if (rnd == 5'd1)
      return win;
    return {win[127:0], n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of the state is bits [127-8i -: 8], column-major.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_rnd,
  output logic [127:0] state_out
);

  logic [15:0][7:0] sb;
  logic [15:0][7:0] sr;
  logic [15:0][7:0] mc;

  always_comb begin
    sb        = '0;
    sr        = '0;
    mc        = '0;
    state_out = '0;
    for (int unsigned i = 0; i < 16; i++)
      sb[i] = sbox(state_in[127 - 8 * i -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int unsigned i = 0; i < 16; i++)
      state_out[127 - 8 * i -: 8] = (final_rnd ? sr[i] : mc[i]) ^ round_key[127 - 8 * i -: 8];
  end

endmodule

// File: rtl/aes_iter_encryptor.sv
// Iterative AES-128/256 encryptor with on-the-fly key expansion, running
// ROUNDS_PER_CYCLE chained rounds per clock between valid/ready handshakes.
module aes_iter_encryptor
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS         = 128,
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy
);

  localparam int unsigned NR     = nr_of(KEY_BITS);
  localparam logic        AES256 = (KEY_BITS == 256);
  localparam logic [4:0]  NR_C   = 5'(NR);
  localparam logic [4:0]  RPC_C  = 5'(ROUNDS_PER_CYCLE);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_encryptor: KEY_BITS must be 128 or 256");
  end
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
    $error("aes_iter_encryptor: ROUNDS_PER_CYCLE must be 1 or 2");
  end

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [255:0] win_q, win_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         rdy_en_q, rdy_en_d;

  logic [127:0] st_chain  [ROUNDS_PER_CYCLE+1];
  logic [255:0] win_chain [ROUNDS_PER_CYCLE+1];

  assign st_chain[0]  = st_q;
  assign win_chain[0] = win_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [4:0] rnd;
    assign rnd            = cnt_q + 5'(g);
    assign win_chain[g+1] = ks_next(win_chain[g], rnd, AES256);
    aes_round u_round (
      .state_in  (st_chain[g]),
      .round_key (win_chain[g+1][127:0]),
      .final_rnd (rnd == NR_C),
      .state_out (st_chain[g+1])
    );
  end

  // rdy_en holds in_ready low until the first edge after reset release.
  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    rdy_en_d  = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = rdy_en_q;
        if (in_valid && rdy_en_q) begin
          fsm_d = RUN;
          st_d  = plaintext ^ key[KEY_BITS-1 -: 128];
          win_d = 256'(key);
          cnt_d = 5'd1;
        end
      end
      RUN: begin
        st_d  = st_chain[ROUNDS_PER_CYCLE];
        win_d = win_chain[ROUNDS_PER_CYCLE];
        cnt_d = cnt_q + RPC_C;
        if (cnt_q + RPC_C > NR_C)
          fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      st_q     <= st_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign ciphertext = st_q;
  assign busy       = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_iter_encryptor.sv
// Scoreboard bench for aes_iter_encryptor across AES-128/256 and 1/2 rounds
// per cycle, against a byte-level FIPS-197 model with a derived S-box.
module tb_aes_iter_encryptor;

  typedef struct {
    int           id;
    logic [127:0] ct;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [3:0]   busy;
  logic [127:0] pt [4];
  logic [255:0] ky [4];
  logic [127:0] ct [4];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q [$];
  int   acc_edge [4];
  bit   ov_prev [4];
  int   lat_exp [4] = '{10, 5, 14, 7};
  int   nk_of [4]   = '{4, 4, 8, 8};
  logic [7:0] sbox_t [256];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned KB  = (g >= 2) ? 256 : 128;
    localparam int unsigned RPC = (g % 2) + 1;
    aes_iter_encryptor #(.KEY_BITS(KB), .ROUNDS_PER_CYCLE(RPC)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .plaintext  (pt[g]),
      .key        (ky[g][KB-1:0]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .ciphertext (ct[g]),
      .busy       (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [255:0] k, input int nk);
    int           nr;
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[32*nk-1-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd != nr) begin
          s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i] && in_ready[i]) acc_edge[i] = cyc + 1;
      if (out_valid[i] && !ov_prev[i])
        chk("latency", i, 128'(cyc - acc_edge[i]), 128'(lat_exp[i]));
      if (in_ready[i] || out_valid[i])
        chk("handshake_flags", i, {125'h0, in_ready[i], out_valid[i], busy[i]},
            in_ready[i] ? 128'h4 : 128'h3);
      if (out_valid[i] && out_ready[i]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", i, ct[i], 128'hx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("output_dut_id", i, 128'(i), 128'(e.id));
          chk("ciphertext", i, ct[i], e.ct);
        end
      end
      ov_prev[i] = out_valid[i];
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k,
                      input logic [127:0] e, input bit keep, output int acc);
    int n = 0;
    acc = -1;
    pt[d] = p;
    ky[d] = k;
    in_valid[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[d] && n < 100);
    if (!in_ready[d]) begin
      chk("accept_timeout", d, 128'(in_ready[d]), 128'h1);
      in_valid[d] = 1'b0;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back('{d, e});
    @(posedge clk);
    #1;
    if (!keep) begin
      in_valid[d] = 1'b0;
      pt[d] = rand128();
      ky[d] = rand256();
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 0, 128'(exp_q.size()), 128'h0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input int d);
    chk("reset_in_ready", d, 128'(in_ready[d]), 128'h0);
    chk("reset_out_valid", d, 128'(out_valid[d]), 128'h0);
    chk("reset_busy", d, 128'(busy[d]), 128'h0);
    chk("reset_ciphertext", d, ct[d], 128'h0);
  endtask

  localparam logic [127:0] V1_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] V1_K  = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] V1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] V2_K  = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] V2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] V3_K  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] V3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int           acc1, acc2;
    logic [127:0] p, held;
    logic [255:0] k;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      pt[i] = '0;
      ky[i] = '0;
      acc_edge[i] = 0;
      ov_prev[i] = 1'b0;
    end
    #1 rst = 1'b0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_reset_vals(i);

    // Release with a block already offered: no accept on the release edge.
    @(posedge clk);
    #1;
    rst = 1'b1;
    pt[0] = V1_PT;
    ky[0] = V1_K;
    in_valid[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("in_ready_before_first_edge", i, 128'(in_ready[i]), 128'h0);
    send(0, V1_PT, V1_K, V1_CT, 1'b0, acc1);
    drain();

    send(1, V2_PT, V2_K, V2_CT, 1'b0, acc1); drain();
    send(2, V2_PT, V3_K, V3_CT, 1'b0, acc1); drain();
    send(3, V2_PT, V3_K, V3_CT, 1'b0, acc1); drain();
    send(0, V2_PT, V2_K, V2_CT, 1'b0, acc1); drain();
    send(1, V1_PT, V1_K, V1_CT, 1'b0, acc1); drain();

    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 4; j++) begin
        p = rand128();
        k = rand256();
        send(d, p, k, aes_ref(p, k, nk_of[d]), 1'b0, acc1);
        drain();
      end
    end

    // Back-pressure: hold DONE for 20 cycles.
    for (int d = 0; d < 4; d += 2) begin
      out_ready[d] = 1'b0;
      p = rand128();
      k = rand256();
      send(d, p, k, aes_ref(p, k, nk_of[d]), 1'b0, acc1);
      begin
        int n = 0;
        while (!out_valid[d] && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
      held = ct[d];
      chk("bp_first_ct", d, held, aes_ref(p, k, nk_of[d]));
      repeat (20) begin
        @(negedge clk);
        chk("bp_ct_stable", d, ct[d], held);
        chk("bp_out_valid", d, 128'(out_valid[d]), 128'h1);
        chk("bp_in_ready", d, 128'(in_ready[d]), 128'h0);
      end
      @(posedge clk);
      #1;
      out_ready[d] = 1'b1;
      drain();
    end

    // Reset in the fourth run cycle discards the block.
    p = rand128();
    k = rand256();
    send(0, p, k, aes_ref(p, k, 4), 1'b0, acc1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_reset_vals(i);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(0, V1_PT, V1_K, V1_CT, 1'b0, acc1);
    drain();

    // Back-to-back with in_valid held high.
    p = rand128();
    k = rand256();
    send(0, p, k, aes_ref(p, k, 4), 1'b1, acc1);
    p = rand128();
    k = rand256();
    send(0, p, k, aes_ref(p, k, 4), 1'b0, acc2);
    chk("b2b_accept_interval", 0, 128'(acc2 - acc1), 128'd12);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
